// File: rtl/dmem_if.sv
// AXI4-style read/write channel bundle between dcache (master) and dmem (slave).
// No IDs, INCR bursts only; widths follow the memory's address and beat widths.
// Handshakes are plain valid/ready on AR, R, AW, W and B.
interface dmem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output araddr, arlen, arvalid, rready,
        output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rdata, rresp, rlast, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arlen, arvalid, rready,
        input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rdata, rresp, rlast, rvalid,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/dmem.sv
// Word-organised data memory, AXI4 slave with independent read and write burst engines.
// Latency: first R beat one cycle after AR handshake; B one cycle after the final W beat.
// Backpressure: R beat held stable while rready low; B held until bready. Contents survive reset.
module dmem #(
    parameter int    ADDR_WIDTH = 32,
    parameter int    DATA_WIDTH = 32,
    parameter int    MEM_WORDS  = 1024,
    parameter string INIT_FILE  = "dmem_init.hex"
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);
    localparam int         IDX_W       = ADDR_WIDTH - 2;
    localparam int         MEM_AW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int         NBYTES      = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic       {R_IDLE, R_BURST}        r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Beat indices wrap over the full index space, so range is checked per beat.
    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return idx < IDX_W'(MEM_WORDS);
    endfunction

    localparam bit INIT_NAMED = (INIT_FILE != "");
    logic unused_init;
    assign unused_init = INIT_NAMED;

    // Byte lane bits of the addresses are ignored by design.
    logic unused_lsb;
    assign unused_lsb = ^{bus.araddr[1:0], bus.awaddr[1:0]};

    // ---------------- read engine ----------------
    r_state_t              r_state, r_state_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [7:0]            r_len, r_beat;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  arready_c, rvalid_c, rlast_c, r_last, ar_hs, r_hs;
    logic [IDX_W-1:0]      fetch_idx;
    logic                  fetch_ok;
    logic [DATA_WIDTH-1:0] fetch_dat;

    assign r_last = (r_beat == r_len);
    assign ar_hs  = bus.arvalid && arready_c;
    assign r_hs   = rvalid_c && bus.rready;

    // Read FSM next state and channel controls.
    always_comb begin
        r_state_nxt = r_state;
        arready_c   = 1'b0;
        rvalid_c    = 1'b0;
        rlast_c     = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready_c = 1'b1;
                if (bus.arvalid) r_state_nxt = R_BURST;
            end
            R_BURST: begin
                rvalid_c = 1'b1;
                rlast_c  = r_last;
                if (bus.rready && r_last) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // Word fetched at the next edge: burst start on AR, else the following beat.
    always_comb begin
        fetch_idx = ar_hs ? bus.araddr[ADDR_WIDTH-1:2] : r_idx + IDX_W'(1);
        fetch_ok  = in_range(fetch_idx);
        fetch_dat = fetch_ok ? mem[fetch_idx[MEM_AW-1:0]] : '0;
    end

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_state_nxt;
    end

    // Read datapath: load a beat on AR or on each non-final R handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (ar_hs) begin
            r_idx   <= fetch_idx;
            r_len   <= bus.arlen;
            r_beat  <= '0;
            rdata_q <= fetch_dat;
            rresp_q <= fetch_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (r_hs && !r_last) begin
            r_idx   <= fetch_idx;
            r_beat  <= r_beat + 8'd1;
            rdata_q <= fetch_dat;
            rresp_q <= fetch_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // ---------------- write engine ----------------
    w_state_t         w_state, w_state_nxt;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_len, w_beat;
    logic             w_err, w_last, aw_hs, w_hs;
    logic             awready_c, wready_c, bvalid_c;

    assign w_last = (w_beat == w_len);
    assign aw_hs  = bus.awvalid && awready_c;
    assign w_hs   = bus.wvalid && wready_c;

    // Write FSM next state and channel controls; beat count alone ends the burst.
    always_comb begin
        w_state_nxt = w_state;
        awready_c   = 1'b0;
        wready_c    = 1'b0;
        bvalid_c    = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready_c = 1'b1;
                if (bus.awvalid) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                wready_c = 1'b1;
                if (bus.wvalid && w_last) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid_c = 1'b1;
                if (bus.bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    // Write FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_state_nxt;
    end

    // Write datapath: beat tracking and sticky error for range or wlast mismatch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_idx  <= '0;
            w_len  <= '0;
            w_beat <= '0;
            w_err  <= 1'b0;
        end else if (aw_hs) begin
            w_idx  <= bus.awaddr[ADDR_WIDTH-1:2];
            w_len  <= bus.awlen;
            w_beat <= '0;
            w_err  <= 1'b0;
        end else if (w_hs) begin
            w_idx  <= w_idx + IDX_W'(1);
            w_beat <= w_beat + 8'd1;
            if (!in_range(w_idx) || (bus.wlast != w_last)) w_err <= 1'b1;
        end
    end

    // Memory array: byte-masked commit of in-range beats; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_hs && in_range(w_idx)) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (bus.wstrb[i]) mem[w_idx[MEM_AW-1:0]][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

    assign bus.arready = arready_c;
    assign bus.rvalid  = rvalid_c;
    assign bus.rlast   = rlast_c;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.awready = awready_c;
    assign bus.wready  = wready_c;
    assign bus.bvalid  = bvalid_c;
    assign bus.bresp   = (bvalid_c && w_err) ? RESP_SLVERR : RESP_OKAY;
endmodule

// File: tb/tb_dmem.sv
// Directed bench for dmem: burst write/read, strobes, backpressure, range and protocol errors, reset.
// All expectations are hand-computed constants.
module tb_dmem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    dmem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(1024), .INIT_FILE("dmem_init.hex")) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] wd [8];
    logic [3:0]  ws [8];
    logic [31:0] rd [8];
    logic [1:0]  rr [8];
    logic        rl [8];
    logic [1:0]  bresp_got;
    int          lat;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len,
                               input int last_at, input int hold);
        int t;
        bus.awaddr  = addr;
        bus.awlen   = len;
        bus.awvalid = 1'b1;
        t = 0;
        while (!bus.awready && t < 50) begin tick(); t++; end
        if (!bus.awready) check("aw_timeout", {31'd0, bus.awready}, 32'd1);
        tick();
        bus.awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            bus.wdata  = wd[b];
            bus.wstrb  = ws[b];
            bus.wlast  = (b == last_at);
            bus.wvalid = 1'b1;
            t = 0;
            while (!bus.wready && t < 50) begin tick(); t++; end
            if (!bus.wready) check("w_timeout", {31'd0, bus.wready}, 32'd1);
            tick();
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        t = 0;
        while (!bus.bvalid && t < 50) begin tick(); t++; end
        if (!bus.bvalid) check("b_timeout", {31'd0, bus.bvalid}, 32'd1);
        for (int h = 0; h < hold; h++) begin
            check($sformatf("b_hold%0d_bvalid", h), {31'd0, bus.bvalid}, 32'd1);
            check($sformatf("b_hold%0d_awready", h), {31'd0, bus.awready}, 32'd0);
            tick();
        end
        bresp_got  = bus.bresp;
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
    endtask

    // exp0 is the known first-beat word, checked for stability while stalled.
    task automatic read_burst(input logic [31:0] addr, input logic [7:0] len,
                              input int stall, input logic [31:0] exp0);
        int t;
        bus.araddr  = addr;
        bus.arlen   = len;
        bus.arvalid = 1'b1;
        t = 0;
        while (!bus.arready && t < 50) begin tick(); t++; end
        if (!bus.arready) check("ar_timeout", {31'd0, bus.arready}, 32'd1);
        tick();
        bus.arvalid = 1'b0;
        lat = 1;
        for (int b = 0; b <= int'(len); b++) begin
            t = 0;
            while (!bus.rvalid && t < 50) begin tick(); t++; lat++; end
            if (!bus.rvalid) check("r_timeout", {31'd0, bus.rvalid}, 32'd1);
            if (b == 0) begin
                for (int s = 0; s < stall; s++) begin
                    tick();
                    check($sformatf("stall%0d_rvalid", s), {31'd0, bus.rvalid}, 32'd1);
                    check($sformatf("stall%0d_rdata", s), bus.rdata, exp0);
                    check($sformatf("stall%0d_rresp", s), {30'd0, bus.rresp}, 32'd0);
                    check($sformatf("stall%0d_rlast", s), {31'd0, bus.rlast}, 32'd0);
                end
            end
            rd[b] = bus.rdata;
            rr[b] = bus.rresp;
            rl[b] = bus.rlast;
            bus.rready = 1'b1;
            tick();
            bus.rready = 1'b0;
        end
    endtask

    initial begin
        bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // reset values: arready awready rvalid rlast wready bvalid
        check("rst_ctrl", {26'd0, bus.arready, bus.awready, bus.rvalid, bus.rlast, bus.wready, bus.bvalid},
              32'b110000);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_resp", {28'd0, bus.rresp, bus.bresp}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: four-beat write then read back
        wd[0] = 32'h11111111; wd[1] = 32'h22222222; wd[2] = 32'h33333333; wd[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        write_burst(32'h40, 8'd3, 3, 0);
        check("t1_bresp", {30'd0, bresp_got}, 32'd0);
        read_burst(32'h40, 8'd3, 0, 32'h0);
        check("t1_latency", lat, 32'd1);
        check("t1_d0", rd[0], 32'h11111111);
        check("t1_d1", rd[1], 32'h22222222);
        check("t1_d2", rd[2], 32'h33333333);
        check("t1_d3", rd[3], 32'h44444444);
        check("t1_rlast", {28'd0, rl[3], rl[2], rl[1], rl[0]}, 32'b1000);
        check("t1_rresp", {24'd0, rr[3], rr[2], rr[1], rr[0]}, 32'd0);

        // 2: strobed partial write
        wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
        write_burst(32'h80, 8'd0, 0, 0);
        wd[0] = 32'h11223344; ws[0] = 4'b0101;
        write_burst(32'h80, 8'd0, 0, 0);
        check("t2_bresp", {30'd0, bresp_got}, 32'd0);
        read_burst(32'h80, 8'd0, 0, 32'h0);
        check("t2_merge", rd[0], 32'hAA22CC44);
        check("t2_rlast", {31'd0, rl[0]}, 32'd1);

        // 3: read backpressure on the first of two beats
        wd[0] = 32'hCAFE0001; wd[1] = 32'hCAFE0002; ws[0] = 4'hF; ws[1] = 4'hF;
        write_burst(32'h100, 8'd1, 1, 0);
        read_burst(32'h100, 8'd1, 3, 32'hCAFE0001);
        check("t3_d0", rd[0], 32'hCAFE0001);
        check("t3_d1", rd[1], 32'hCAFE0002);
        check("t3_rlast", {30'd0, rl[1], rl[0]}, 32'b10);

        // 4: burst crossing the top of memory
        wd[0] = 32'h5A5A5A5A; wd[1] = 32'hDEADBEEF; ws[0] = 4'hF; ws[1] = 4'hF;
        write_burst(32'hFFC, 8'd1, 1, 0);
        check("t4_bresp", {30'd0, bresp_got}, 32'd2);
        read_burst(32'hFFC, 8'd1, 0, 32'h0);
        check("t4_d0", rd[0], 32'h5A5A5A5A);
        check("t4_r0", {30'd0, rr[0]}, 32'd0);
        check("t4_d1", rd[1], 32'h0);
        check("t4_r1", {30'd0, rr[1]}, 32'd2);

        // 5: early wlast, response held under bready low
        wd[0] = 32'h0000A001; wd[1] = 32'h0000A002; wd[2] = 32'h0000A003;
        for (int i = 0; i < 3; i++) ws[i] = 4'hF;
        write_burst(32'h200, 8'd2, 1, 4);
        check("t5_bresp", {30'd0, bresp_got}, 32'd2);
        check("t5_idle_awready", {31'd0, bus.awready}, 32'd1);
        read_burst(32'h200, 8'd2, 0, 32'h0);
        check("t5_d2", rd[2], 32'h0000A003);

        // 6: reset during beat 2 of an eight-beat read
        for (int i = 0; i < 8; i++) begin wd[i] = 32'h60 + i; ws[i] = 4'hF; end
        write_burst(32'h300, 8'd7, 7, 0);
        bus.araddr = 32'h300; bus.arlen = 8'd7; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check("t6_beat2_rvalid", {31'd0, bus.rvalid}, 32'd1);
        check("t6_beat2_rdata", bus.rdata, 32'h61);
        #2 rst = 1'b1;
        #1;
        check("t6_async_rvalid", {31'd0, bus.rvalid}, 32'd0);
        check("t6_async_rdata", bus.rdata, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_rel_ctrl", {28'd0, bus.arready, bus.awready, bus.rvalid, bus.bvalid}, 32'b1100);
        read_burst(32'h300, 8'd7, 0, 32'h0);
        for (int i = 0; i < 8; i++) check($sformatf("t6_d%0d", i), rd[i], 32'h60 + i);
        check("t6_rlast", {31'd0, rl[7]}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
